// File: rtl/fb_pkg.sv
// Shared types and widths for the FBCPU program loader controller.
package fb_pkg;

    localparam int FB_ADDR_W = 6;
    localparam int FB_DATA_W = 10;
    localparam int FB_CYC_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } fb_ldr_state_t;

endpackage

// File: rtl/fb_loader_ctrl_ram_mux.sv
// RAM port selector: the registered loader write, or the FBCPU port
// passed through combinationally while the CPU runs.
module fb_ram_mux
    import fb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = FB_ADDR_W,
    parameter int DATA_WIDTH    = FB_DATA_W
) (
    input  logic                     sel_cpu,
    input  logic [ADDRESS_WIDTH-1:0] ldr_addr,
    input  logic                     ldr_we,
    input  logic [DATA_WIDTH-1:0]    ldr_wdata,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic                     cpu_we,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_we,
    output logic [DATA_WIDTH-1:0]    ram_wdata
);

    // Same-cycle CPU path when selected; loader registers otherwise.
    always_comb begin
        if (sel_cpu) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end else begin
            ram_addr  = ldr_addr;
            ram_we    = ldr_we;
            ram_wdata = ldr_wdata;
        end
    end

endmodule

// File: rtl/fb_loader_ctrl.sv
// FBCPU loader/sequencer: holds the CPU in reset, streams a program image
// into RAM, releases the CPU and counts run cycles.
// Optional feature macro: FB_WATCHDOG_EN (run-cycle watchdog with sticky timeout).
module fb_loader_ctrl
    import fb_pkg::*;
#(
    parameter int                    ADDRESS_WIDTH = FB_ADDR_W,
    parameter int                    DATA_WIDTH    = FB_DATA_W,
    parameter logic [FB_CYC_W-1:0]   WDOG_LIMIT    = 16'd1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     cpu_rst,
    input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
    input  logic                     cpu_ramwr,
    input  logic [DATA_WIDTH-1:0]    cpu_mdrin,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_we,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    output logic                     busy,
    output logic                     running,
    output logic [FB_CYC_W-1:0]      run_cycles,
    output logic                     timeout
);

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [FB_CYC_W-1:0]      CYC_MAX   = '1;
    localparam logic [FB_CYC_W-1:0]      WDOG_LAST = WDOG_LIMIT - FB_CYC_W'(1);

    // A zero limit would make the watchdog compare wrap around.
    if (WDOG_LIMIT == '0) begin : g_bad_wdog_limit
        $error("fb_loader_ctrl: WDOG_LIMIT must be nonzero");
    end

    fb_ldr_state_t              state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [FB_CYC_W-1:0]        run_cycles_q, run_cycles_d;
    logic                       wr_we_q, wr_we_d;
    logic [ADDRESS_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
    logic                       handshake;
`ifdef FB_WATCHDOG_EN
    logic                       timeout_q, timeout_d;
`endif

    assign handshake = (state_q == ST_LOAD) && load_valid;

    // Next-state, address counter, run counter and registered loader write.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        run_cycles_d = run_cycles_q;
        wr_we_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
`ifdef FB_WATCHDOG_EN
        timeout_d    = timeout_q;
`endif
        if (load_start) begin
            // A new load wins over everything, including a word offered the same cycle.
            state_d      = ST_LOAD;
            addr_d       = '0;
            run_cycles_d = '0;
`ifdef FB_WATCHDOG_EN
            timeout_d    = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_LOAD: begin
                    if (handshake) begin
                        wr_we_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = load_data;
                        // Counter holds at the top address so a full image never wraps.
                        if (load_last || (addr_q == ADDR_LAST)) begin
                            state_d = ST_RELEASE;
                        end else begin
                            addr_d = addr_q + ADDRESS_WIDTH'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (run_cycles_q != CYC_MAX) begin
                        run_cycles_d = run_cycles_q + FB_CYC_W'(1);
                    end
`ifdef FB_WATCHDOG_EN
                    if (run_cycles_q == WDOG_LAST) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            run_cycles_q <= '0;
            wr_we_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            run_cycles_q <= run_cycles_d;
            wr_we_q      <= wr_we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

`ifdef FB_WATCHDOG_EN
    // Sticky watchdog flag, cleared only by the next load_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // cpu_rst drops only in RUN, and rises immediately when a load aborts the run.
    assign cpu_rst    = (state_q != ST_RUN) || load_start;
    assign load_ready = (state_q == ST_LOAD);
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_RELEASE);
    assign running    = (state_q == ST_RUN);
    assign run_cycles = run_cycles_q;

    fb_ram_mux #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram_mux (
        .sel_cpu   (running),
        .ldr_addr  (wr_addr_q),
        .ldr_we    (wr_we_q),
        .ldr_wdata (wr_data_q),
        .cpu_addr  (cpu_mar),
        .cpu_we    (cpu_ramwr),
        .cpu_wdata (cpu_mdrin),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata)
    );

endmodule

// File: tb/tb_fb_loader_ctrl.sv
// Bench for fb_loader_ctrl: randomized loads/runs against a behavioural model,
// plus literal checks of reset, latency, image contents and watchdog.
module tb_fb_loader_ctrl;

    localparam int          AW      = 6;
    localparam int          DW      = 10;
    localparam int          DEPTH   = 64;
    localparam logic [15:0] TB_WDOG = 16'd50;
    localparam int P_IDLE = 0, P_LOAD = 1, P_REL = 2, P_RUN = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_ready, cpu_rst;
    logic [AW-1:0] cpu_mar = '0;
    logic          cpu_ramwr = 1'b0;
    logic [DW-1:0] cpu_mdrin = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic          busy, running, timeout;
    logic [15:0]   run_cycles;

    int n_chk = 0;
    int n_fail = 0;
    bit cpu_wr_en = 1'b0;

    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] dut_mem [DEPTH];

    // Behavioural model state
    int            m_phase = P_IDLE;
    int            m_cnt = 0;
    int            m_runc = 0;
    bit            m_timeout = 1'b0;
    bit            m_pend = 1'b0;
    int            m_wa = 0;
    logic [DW-1:0] m_wd = '0;

    fb_loader_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WDOG_LIMIT(TB_WDOG)) dut (
        .clk(clk), .rst(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .cpu_rst(cpu_rst),
        .cpu_mar(cpu_mar), .cpu_ramwr(cpu_ramwr), .cpu_mdrin(cpu_mdrin),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .busy(busy), .running(running), .run_cycles(run_cycles), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one step per clock from the spec's rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE; m_cnt = 0; m_runc = 0; m_timeout = 1'b0; m_pend = 1'b0;
        end else begin
            if (m_phase == P_RUN) begin
                if (cpu_ramwr) exp_mem[cpu_mar] = cpu_mdrin;
            end else if (m_pend) begin
                exp_mem[m_wa] = m_wd;
            end
            m_pend = 1'b0;
            if (load_start) begin
                m_phase = P_LOAD; m_cnt = 0; m_runc = 0; m_timeout = 1'b0;
            end else if (m_phase == P_LOAD) begin
                if (load_valid) begin
                    m_pend = 1'b1; m_wa = m_cnt; m_wd = load_data;
                    if (load_last || m_cnt == DEPTH - 1) m_phase = P_REL;
                    else m_cnt = m_cnt + 1;
                end
            end else if (m_phase == P_REL) begin
                m_phase = P_RUN;
            end else if (m_phase == P_RUN) begin
                if (m_runc < 65535) m_runc = m_runc + 1;
`ifdef FB_WATCHDOG_EN
                if (m_runc == int'(TB_WDOG)) begin
                    m_phase = P_IDLE; m_timeout = 1'b1;
                end
`endif
            end
        end
    end

    // Compare process: every cycle out of reset, mid low phase.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cpu_rst", cpu_rst, (m_phase != P_RUN) || load_start);
            chk("load_ready", load_ready, m_phase == P_LOAD);
            chk("busy", busy, (m_phase == P_LOAD) || (m_phase == P_REL));
            chk("running", running, m_phase == P_RUN);
            chk("run_cycles", run_cycles, m_runc);
            chk("timeout", timeout, m_timeout);
            if (m_phase == P_RUN) begin
                chk("ram_we_cpu", ram_we, cpu_ramwr);
                chk("ram_addr_cpu", ram_addr, cpu_mar);
                chk("ram_wdata_cpu", ram_wdata, cpu_mdrin);
            end else begin
                chk("ram_we_ldr", ram_we, m_pend);
                if (m_pend) begin
                    chk("ram_addr_ldr", ram_addr, m_wa);
                    chk("ram_wdata_ldr", ram_wdata, m_wd);
                end
            end
            if (ram_we) dut_mem[ram_addr] = ram_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cpu_mar   = AW'($urandom_range(0, DEPTH - 1));
        cpu_mdrin = DW'($urandom_range(0, 1023));
        cpu_ramwr = cpu_wr_en && ($urandom_range(0, 1) == 1);
    endtask

    task automatic pulse_start();
        load_start = 1'b1; tick(); load_start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit last);
        load_valid = 1'b1; load_data = d; load_last = last;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic wait_running(input int budget);
        int n = 0;
        while (!running && n < budget) begin tick(); n++; end
        chk("wait_running", running, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cpu_rst"}, cpu_rst, 1);
        chk({tag, "_load_ready"}, load_ready, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_run_cycles"}, run_cycles, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin : watchdog_guard
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish by 2ms");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [DW-1:0] img [4];
        logic [DW-1:0] wds [DEPTH];
        int n;
        img[0] = 10'h005; img[1] = 10'h089; img[2] = 10'h0C6; img[3] = 10'h240;
        for (int i = 0; i < DEPTH; i++) begin exp_mem[i] = '0; dut_mem[i] = '0; end

        // Power-on reset
        #1 rst_n = 1'b0;
        tick(); tick();
        check_reset_vals("por");
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a load
        pulse_start();
        send(10'h3AA, 1'b0); send(10'h155, 1'b0); send(10'h2F0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_vals("midload");
        tick();
        rst_n = 1'b1;
        tick();
        chk("midload_w0", dut_mem[0], 10'h3AA);
        chk("midload_w1", dut_mem[1], 10'h155);
        chk("midload_w2_killed", dut_mem[2], 10'h000);

        // 4-word program with load_last on the final word
        cpu_wr_en = 1'b1;
        pulse_start();
        for (int k = 0; k < 4; k++) send(img[k], k == 3);
        chk("release_busy", busy, 1);
        chk("release_ready", load_ready, 0);
        chk("release_running", running, 0);
        tick();
        chk("running_2_after_last", running, 1);
        for (int k = 0; k < 4; k++) chk("img4_word", dut_mem[k], img[k]);
        repeat (5) tick();

        // Backpressure: load_valid every other cycle, random idle data
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            wds[k] = DW'($urandom_range(0, 1023));
            send(wds[k], k == 7);
            if (k != 7) begin
                load_data = DW'($urandom_range(0, 1023));
                tick();
            end
        end
        wait_running(5);
        for (int k = 0; k < 8; k++) chk("bp_word", dut_mem[k], wds[k]);

        // Abort during RUN at run cycle 20
        n = 0;
        while (run_cycles != 16'd20 && n < 100) begin tick(); n++; end
        chk("reach_run20", run_cycles, 20);
        load_start = 1'b1;
        #1;
        chk("abort_cpu_rst_same_cycle", cpu_rst, 1);
        tick();
        load_start = 1'b0;
        chk("abort_in_load", load_ready, 1);
        chk("abort_run_cycles", run_cycles, 0);

        // Full 64-word image, no load_last
        for (int k = 0; k < DEPTH; k++) begin
            wds[k] = DW'($urandom_range(0, 1023));
            send(wds[k], 1'b0);
        end
        chk("full_release_busy", busy, 1);
        chk("full_release_ready", load_ready, 0);
        tick();
        chk("full_running", running, 1);
        for (int k = 0; k < DEPTH; k++) chk("full_word", dut_mem[k], wds[k]);

        // JMP-to-self program and the watchdog
        pulse_start();
        send(10'h180, 1'b1);
        tick();
        chk("wd_run_start", running, 1);
`ifdef FB_WATCHDOG_EN
        n = 0;
        while (running && n < 300) begin tick(); n++; end
        chk("wd_cycles_to_fire", n, 50);
        chk("wd_timeout", timeout, 1);
        chk("wd_idle", busy || running, 0);
        chk("wd_cpu_rst", cpu_rst, 1);
        chk("wd_run_cycles", run_cycles, 50);
        repeat (3) tick();
        chk("wd_run_cycles_frozen", run_cycles, 50);
        chk("wd_sticky", timeout, 1);
`else
        repeat (200) tick();
        chk("nowd_running", running, 1);
        chk("nowd_timeout", timeout, 0);
        chk("nowd_run_cycles", run_cycles, 200);
`endif
        pulse_start();
        chk("restart_timeout_clear", timeout, 0);
        chk("restart_load", load_ready, 1);
        send(DW'($urandom_range(0, 1023)), 1'b1);
        wait_running(5);
        repeat (10) tick();

        // Final whole-RAM consistency
        for (int i = 0; i < DEPTH; i++) chk("final_mem", dut_mem[i], exp_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
